// File: rtl/nest_block_checker.sv
// nest_block_checker: streaming "begin"/"end" nesting checker.
// Splits an ASCII stream into space-delimited words and tracks the nesting depth.
// A completed keyword is held as pending until the next space commits it.
// Any other character after the keyword cancels the pending update.
// All outputs are registered and show the effect of the char accepted on the previous edge.
module nest_block_checker #(
    parameter int DEPTH_W   = 8,
    parameter bit CASE_SENS = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in,
    input  logic               in_valid,
    output logic               result,
    output logic [DEPTH_W-1:0] depth,
    output logic               error,
    output logic               overflow
);

    localparam logic [DEPTH_W-1:0] MAX_DEPTH = '1;
    localparam logic [DEPTH_W-1:0] ZERO      = '0;
    localparam logic [DEPTH_W-1:0] ONE       = {{(DEPTH_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE, S_B, S_BE, S_BEG, S_BEGI, S_BEGIN, S_E, S_EN, S_END, S_OTHER
    } word_t;

    typedef enum logic [1:0] {P_NONE, P_BEGIN, P_END} pend_t;

    word_t              st_q, st_n;
    pend_t              pend_q, pend_n;
    logic [DEPTH_W-1:0] d_q, d_n, eff_n;
    logic               err_n, ovf_n, res_n;
    logic [7:0]         c;

    // Fold upper case to lower case unless exact matching is requested
    always_comb begin
        c = in;
        if (!CASE_SENS && in >= 8'h41 && in <= 8'h5A)
            c = in | 8'h20;
    end

    // Word FSM step, keyword commit/cancel and next effective depth
    always_comb begin
        st_n   = st_q;
        pend_n = pend_q;
        d_n    = d_q;
        err_n  = error;
        ovf_n  = overflow;
        if (in_valid) begin
            if (c == 8'h20) begin
                // A space closes the word and commits a completed keyword
                st_n   = S_IDLE;
                pend_n = P_NONE;
                if (st_q == S_BEGIN) begin
                    if (d_q == MAX_DEPTH) begin
                        ovf_n = 1'b1;
                        err_n = 1'b1;
                    end else begin
                        d_n = d_q + ONE;
                    end
                end else if (st_q == S_END) begin
                    if (d_q == ZERO) err_n = 1'b1;
                    else             d_n   = d_q - ONE;
                end
            end else begin
                st_n = S_OTHER;
                unique case (st_q)
                    S_IDLE:  if (c == "b") st_n = S_B;
                             else if (c == "e") st_n = S_E;
                    S_B:     if (c == "e") st_n = S_BE;
                    S_BE:    if (c == "g") st_n = S_BEG;
                    S_BEG:   if (c == "i") st_n = S_BEGI;
                    S_BEGI:  if (c == "n") begin
                                 st_n   = S_BEGIN;
                                 pend_n = P_BEGIN;
                             end
                    S_E:     if (c == "n") st_n = S_EN;
                    S_EN:    if (c == "d") begin
                                 st_n   = S_END;
                                 pend_n = P_END;
                             end
                    // A letter after a complete keyword makes it an ordinary word
                    S_BEGIN, S_END: pend_n = P_NONE;
                    default: st_n = S_OTHER;
                endcase
            end
        end

        unique case (pend_n)
            P_BEGIN: eff_n = (d_n == MAX_DEPTH) ? MAX_DEPTH : d_n + ONE;
            P_END:   eff_n = (d_n == ZERO) ? ZERO : d_n - ONE;
            default: eff_n = d_n;
        endcase
        // A pending "end" at depth 0 is an error in waiting, so it is not balanced
        res_n = !err_n && (eff_n == ZERO) && !(pend_n == P_END && d_n == ZERO);
    end

    // State and registered outputs; reset wins over any accepted char
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q     <= S_IDLE;
            pend_q   <= P_NONE;
            d_q      <= ZERO;
            result   <= 1'b1;
            depth    <= ZERO;
            error    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            st_q     <= st_n;
            pend_q   <= pend_n;
            d_q      <= d_n;
            result   <= res_n;
            depth    <= eff_n;
            error    <= err_n;
            overflow <= ovf_n;
        end
    end

endmodule
